// File: rtl/key_pkg.sv
// key_pkg: FSM state encodings and default timing constants for the key conditioner
package key_pkg;

    typedef enum logic [1:0] {WAIT_REL, IDLE, PRESSED, REPEAT} key_state_t;

    localparam int DEB_CYC_DEF  = 1000000;
    localparam int HOLD_CYC_DEF = 30000000;
    localparam int REP_CYC_DEF  = 7500000;

endpackage

// File: rtl/key_sync_debounce.sv
// key_sync_debounce: polarity fix, 2-flop synchroniser and debounce counter
// Ports: clk, rst (async, active-high), key_in (raw pin), deb (debounced, 1 = pressed)
module key_sync_debounce #(
    parameter int DEB_CYC    = 1000000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic deb
);

    localparam int CW = $clog2(DEB_CYC + 1);

    logic          raw;
    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    assign raw = (ACTIVE_LOW != 0) ? ~key_in : key_in;

    // deb resets to pressed so a key held through reset is treated as already down
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b00;
            cnt  <= '0;
            deb  <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == deb) begin
                cnt <= '0;
            end else if (cnt == CW'(DEB_CYC - 1)) begin
                cnt <= '0;
                deb <= ~deb;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/key_debounce_repeat.sv
// key_debounce_repeat: debounced key with press pulse, long-press pulse and optional auto-repeat
// Ports: clk, rst (async, active-high), key_in (raw pin),
//        key_level (debounced pressed), key_pulse (press/repeat pulse), key_long (long-press pulse)
// Define KEY_AUTO_REPEAT_EN to emit repeat pulses every REP_CYC cycles while held past HOLD_CYC.
module key_debounce_repeat
    import key_pkg::*;
#(
    parameter int DEB_CYC    = DEB_CYC_DEF,
    parameter int HOLD_CYC   = HOLD_CYC_DEF,
    parameter int REP_CYC    = REP_CYC_DEF,
    parameter int ACTIVE_LOW = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_level,
    output logic key_pulse,
    output logic key_long
);

    localparam int HW = $clog2(HOLD_CYC + 1);

    if (DEB_CYC < 1 || HOLD_CYC < 1 || REP_CYC < 1) begin : g_bad_params
        $error("key_debounce_repeat: timing parameters must be >= 1");
    end

    logic          deb;
    key_state_t    state, state_nx;
    logic [HW-1:0] hcnt, hcnt_nx;

    key_sync_debounce #(.DEB_CYC(DEB_CYC), .ACTIVE_LOW(ACTIVE_LOW)) u_deb (
        .clk    (clk),
        .rst    (rst),
        .key_in (key_in),
        .deb    (deb)
    );

    assign key_level = deb && state != WAIT_REL;

`ifdef KEY_AUTO_REPEAT_EN
    localparam int RW = $clog2(REP_CYC + 1);
    logic [RW-1:0] rcnt, rcnt_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rcnt <= '0;
        else     rcnt <= rcnt_nx;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= WAIT_REL;
            hcnt  <= '0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
        end
    end

    // counters default to clear; they only advance while held in their own state,
    // and each tops out at its terminal value minus one, so neither can wrap
    always_comb begin
        state_nx  = state;
        hcnt_nx   = '0;
        key_pulse = 1'b0;
        key_long  = 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        rcnt_nx   = '0;
`endif
        case (state)
            WAIT_REL: state_nx = deb ? WAIT_REL : IDLE;
            IDLE: begin
                key_pulse = deb;
                state_nx  = deb ? PRESSED : IDLE;
            end
            PRESSED: begin
                if (!deb) begin
                    state_nx = IDLE;
                end else if (hcnt == HW'(HOLD_CYC - 1)) begin
                    key_long = 1'b1;
                    state_nx = REPEAT;
`ifdef KEY_AUTO_REPEAT_EN
                    key_pulse = 1'b1;
`endif
                end else begin
                    hcnt_nx = hcnt + HW'(1);
                end
            end
            REPEAT: begin
                state_nx = deb ? REPEAT : IDLE;
`ifdef KEY_AUTO_REPEAT_EN
                key_pulse = deb && rcnt == RW'(REP_CYC - 1);
                rcnt_nx   = (deb && !key_pulse) ? rcnt + RW'(1) : '0;
`endif
            end
            default: state_nx = WAIT_REL;
        endcase
    end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// tb_key_debounce_repeat: directed self-checking bench for key_debounce_repeat
module tb_key_debounce_repeat;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key_in = 1'b0;
    logic key_level, key_pulse, key_long;
    int   checks = 0;
    int   errors = 0;

    key_debounce_repeat #(.DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(8), .ACTIVE_LOW(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_level (key_level),
        .key_pulse (key_pulse),
        .key_long  (key_long)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        key_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({key_level, key_pulse, key_long} !== 3'b000) begin
            errors++;
            $display("FAIL reset_hold: got %b exp 000", {key_level, key_pulse, key_long});
        end
        rst = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1 key_in = 1'b0;
            @(negedge clk);
            checks++;
            if ({key_level, key_pulse, key_long} !== 3'b000) begin
                errors++;
                $display("FAIL reset_idle t=%0d: got %b exp 000", t, {key_level, key_pulse, key_long});
            end
        end
    endtask

    task automatic test_clean_press();
        logic el, ep, eg;
        for (int t = 0; t < 40; t++) begin
            @(posedge clk); #1 key_in = (t >= 20 && t < 30);
            @(negedge clk);
            el = (t >= 26 && t < 36);
            ep = (t == 26);
            eg = 1'b0;
            checks += 3;
            if (key_level !== el) begin errors++; $display("FAIL clean_level t=%0d: got %b exp %b", t, key_level, el); end
            if (key_pulse !== ep) begin errors++; $display("FAIL clean_pulse t=%0d: got %b exp %b", t, key_pulse, ep); end
            if (key_long  !== eg) begin errors++; $display("FAIL clean_long t=%0d: got %b exp %b", t, key_long, eg); end
        end
    endtask

    task automatic test_bounce();
        logic [11:0] pat = 12'b000100111011;
        logic el, ep;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk);
            #1 key_in = (t >= 10 && t < 22) ? pat[t-10] : (t >= 22 && t < 40);
            @(negedge clk);
            el = (t >= 28 && t < 46);
            ep = (t == 28);
            checks += 3;
            if (key_level !== el)   begin errors++; $display("FAIL bounce_level t=%0d: got %b exp %b", t, key_level, el); end
            if (key_pulse !== ep)   begin errors++; $display("FAIL bounce_pulse t=%0d: got %b exp %b", t, key_pulse, ep); end
            if (key_long  !== 1'b0) begin errors++; $display("FAIL bounce_long t=%0d: got %b exp 0", t, key_long); end
        end
    endtask

    task automatic test_repeat();
        logic el, ep, eg;
        for (int t = 0; t < 90; t++) begin
            @(posedge clk); #1 key_in = (t >= 20 && t < 70);
            @(negedge clk);
            el = (t >= 26 && t < 76);
            eg = (t == 46);
`ifdef KEY_AUTO_REPEAT_EN
            ep = (t == 26 || t == 46 || t == 54 || t == 62 || t == 70);
`else
            ep = (t == 26);
`endif
            checks += 3;
            if (key_level !== el) begin errors++; $display("FAIL repeat_level t=%0d: got %b exp %b", t, key_level, el); end
            if (key_pulse !== ep) begin errors++; $display("FAIL repeat_pulse t=%0d: got %b exp %b", t, key_pulse, ep); end
            if (key_long  !== eg) begin errors++; $display("FAIL repeat_long t=%0d: got %b exp %b", t, key_long, eg); end
        end
    endtask

    task automatic test_release_on_hold();
        logic el, ep;
        for (int t = 0; t < 60; t++) begin
            @(posedge clk); #1 key_in = (t >= 20 && t < 40);
            @(negedge clk);
            el = (t >= 26 && t < 46);
            ep = (t == 26);
            checks += 3;
            if (key_level !== el)   begin errors++; $display("FAIL relhold_level t=%0d: got %b exp %b", t, key_level, el); end
            if (key_pulse !== ep)   begin errors++; $display("FAIL relhold_pulse t=%0d: got %b exp %b", t, key_pulse, ep); end
            if (key_long  !== 1'b0) begin errors++; $display("FAIL relhold_long t=%0d: got %b exp 0", t, key_long); end
        end
    endtask

    task automatic test_held_through_reset();
        logic el, ep;
        @(negedge clk);
        key_in = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(posedge clk); #1 key_in = (t < 30);
            @(negedge clk);
            checks++;
            if ({key_level, key_pulse, key_long} !== 3'b000) begin
                errors++;
                $display("FAIL held_reset_quiet t=%0d: got %b exp 000", t, {key_level, key_pulse, key_long});
            end
        end
        for (int t = 0; t < 20; t++) begin
            @(posedge clk); #1 key_in = (t < 10);
            @(negedge clk);
            el = (t >= 6 && t < 16);
            ep = (t == 6);
            checks += 2;
            if (key_level !== el) begin errors++; $display("FAIL held_reset_level t=%0d: got %b exp %b", t, key_level, el); end
            if (key_pulse !== ep) begin errors++; $display("FAIL held_reset_pulse t=%0d: got %b exp %b", t, key_pulse, ep); end
        end
    endtask

    task automatic test_async_reset();
        for (int t = 0; t < 12; t++) begin
            @(posedge clk); #1 key_in = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (key_level !== 1'b1) begin errors++; $display("FAIL async_pre_level: got %b exp 1", key_level); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({key_level, key_pulse, key_long} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset_drop: got %b exp 000", {key_level, key_pulse, key_long});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int t = 0; t < 24; t++) begin
            @(posedge clk); #1 key_in = (t < 10);
            @(negedge clk);
            checks++;
            if ({key_level, key_pulse, key_long} !== 3'b000) begin
                errors++;
                $display("FAIL async_reenter t=%0d: got %b exp 000", t, {key_level, key_pulse, key_long});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_repeat();
        test_release_on_hold();
        test_held_through_reset();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
